led_sched: RTL
==============

# led_sched

Time-shares the Fomu RGB LED driver between several requesters, such as a USB-activity indicator or a user status source. The block sequences current-source power-up and arbitrates requests round-robin. It holds the winner's colour for a requested number of milliseconds and produces the three PWM signals and enables for the SB_RGBA_DRV hard macro. When nothing is granted, it shows a green heartbeat.

## Interface
- NREQ, 2 — number of requesters (1..4)
- CLK_HZ, 48000000 — clk frequency
- TICK_HZ, 1000 — timebase; one tick = 1 ms
- WARMUP_CYCLES, 4800 — CURREN-to-RGBLEDEN settle time (100 us)
- HB_DUTY, 8'h40 — heartbeat green duty
- HB_PERIOD, 1000 — heartbeat period in ticks; on for the first half
- clk  in  1  system clock, 48 MHz, from global buffer
- rst_n  in  1  synchronous, active-low reset
- req  in  NREQ  request per requester, level
- colour  in  24*NREQ  per requester: {R[23:16], G[15:8], B[7:0]} duty
- hold_ms  in  16*NREQ  per requester display time in ticks
- grant  out  NREQ  one-hot; high for the whole display slot
- done  out  1  one-cycle pulse on the last cycle of a slot
- busy  out  1  high in SHOW
- curren  out  1  to SB_RGBA_DRV CURREN
- rgbleden  out  1  to SB_RGBA_DRV RGBLEDEN
- red_pwm, green_pwm, blue_pwm  out  1 each  to the PWM inputs (board colour mapping is done by the instantiating top)

## Operation
- Reset is synchronous and active-low on rst_n. All outputs are 0 while rst_n is low, and for the first cycle after release.
- States: OFF, WARMUP, IDLE, SHOW.
- OFF: curren=0, rgbleden=0. Unconditionally go to WARMUP on the next cycle.
- WARMUP: curren=1. Count WARMUP_CYCLES cycles, then go to IDLE. Requests stay pending and are not granted.
- IDLE: curren=1, rgbleden=1. Duties are R=0, B=0, G=HB_DUTY while the heartbeat counter is below HB_PERIOD/2, otherwise G=0.
- IDLE with any req high: on that edge, select the winner round-robin and latch its colour and hold_ms. Assert grant for the winner and go to SHOW.
- Round-robin: search starts at the index after the last winner. The pointer resets to 0, so requester 0 wins first.
- SHOW: duties = latched colour. If hold_cnt==0, assert done, drop grant on the next edge, and return to IDLE. Otherwise decrement hold_cnt on each tick.
- req may fall during SHOW; this is ignored and the slot completes.
- A req still high after done is re-arbitrated from IDLE. Rotation guarantees other pending requesters win first.
- PWM: one free-running 8-bit counter shared by all channels. Each output is the registered value of (cnt < duty).
  - duty 0: constantly low.
  - duty 255: high 255 of every 256 cycles.
- Tick prescaler: free-running from reset, one-cycle tick every CLK_HZ/TICK_HZ cycles.
- Heartbeat counter: runs on ticks and wraps at HB_PERIOD-1. It keeps running during SHOW.

## Timing
- curren rises on the 2nd cycle after rst_n goes high (1 cycle in OFF).
- rgbleden rises exactly WARMUP_CYCLES cycles after curren.
- Grant latency: req sampled high in IDLE gives grant and busy high on the next cycle.
- New duty takes effect on PWM outputs 1 cycle after the state change, because outputs are registered.
- SHOW length: hold_ms=0 gives exactly 1 cycle, with done in that cycle. hold_ms=N gives (N-1) ticks + 1 cycle up to N ticks + 1 cycle.
- done coincides with the last grant cycle. grant=0 on the following cycle. The earliest next grant is 1 cycle later (1 cycle in IDLE).
- Reset mid-SHOW: on the edge where rst_n is sampled low, grant, busy, PWM outputs and enables go to 0 with no done pulse. Power-up then restarts from OFF.

## Structure
- Package fomu_led_pkg:
  - rgb_t, a packed struct {r, g, b} of 8-bit fields
  - the state enum (OFF, WARMUP, IDLE, SHOW)
  - PWM_BITS=8
  - the colour field offsets
- Sub-module rgb_pwm:
  - holds the shared 8-bit counter and the three compare-and-register channels
  - inputs: clk, rst_n, rgb_t duty
  - outputs: the 3 PWM signals
- led_sched contains the FSM, the prescaler, the heartbeat counter, the hold counter and the round-robin arbiter.

## Test plan
- Parameters for all scenarios: CLK_HZ=16000, TICK_HZ=1000 (16-cycle tick), WARMUP_CYCLES=8.
- Reset release → curren=1 at cycle 2 and rgbleden=1 at cycle 10. Measured over 256 cycles in IDLE: green_pwm high 64 times, red and blue never high. req0 pulsed during WARMUP is not granted before cycle 11.
- req0 with colour 24'hFF0080, hold_ms=3 → grant=2'b01 one cycle after req. Per 256 cycles: red high 255, green 0, blue 128. done pulses once, 33..49 cycles after grant.
- req0 and req1 rise in the same cycle and are held → grant order 01, 10, 01, 10. Each done pulse is followed by grant low for exactly 1 cycle.
- req1 with hold_ms=0 → grant high for exactly 1 cycle, with done and busy high in that same cycle.
- rst_n low for 1 cycle during SHOW (hold_ms=100) → next cycle: grant, busy, all PWM, curren and rgbleden = 0, no done. curren returns 2 cycles after rst_n goes high.

Source files
------------

// File: rtl/fomu_led_pkg.sv
// Shared types and constants for the Fomu RGB LED scheduler.
package fomu_led_pkg;

    localparam int PWM_BITS = 8;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [PWM_BITS-1:0] r;
        logic [PWM_BITS-1:0] g;
        logic [PWM_BITS-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WARMUP,
        ST_IDLE,
        ST_SHOW
    } state_t;

    function automatic rgb_t unpack_colour(input logic [23:0] c);
        rgb_t res;
        res.r = c[R_LSB +: PWM_BITS];
        res.g = c[G_LSB +: PWM_BITS];
        res.b = c[B_LSB +: PWM_BITS];
        return res;
    endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Three PWM channels sharing one free-running counter; outputs are registered
// compares so a new duty shows up one cycle after it is presented.
module rgb_pwm
    import fomu_led_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  rgb_t duty,
    output logic red_pwm,
    output logic green_pwm,
    output logic blue_pwm
);

    logic [PWM_BITS-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            red_pwm   <= 1'b0;
            green_pwm <= 1'b0;
            blue_pwm  <= 1'b0;
        end else begin
            cnt       <= cnt + 1'b1;
            red_pwm   <= (cnt < duty.r);
            green_pwm <= (cnt < duty.g);
            blue_pwm  <= (cnt < duty.b);
        end
    end

endmodule

// File: rtl/led_sched.sv
// Round-robin scheduler for the RGB LED driver with current-source power-up
// sequencing and a green heartbeat when no requester owns the LED.
//
// state  | meaning
// OFF    | drivers disabled, one cycle after reset
// WARMUP | CURREN on, waiting for the current reference to settle
// IDLE   | LED enabled, heartbeat shown, arbitrating requests
// SHOW   | granted requester's colour held for its hold time
module led_sched
    import fomu_led_pkg::*;
#(
    parameter int          NREQ          = 2,
    parameter int          CLK_HZ        = 48000000,
    parameter int          TICK_HZ       = 1000,
    parameter int          WARMUP_CYCLES = 4800,
    parameter logic [7:0]  HB_DUTY       = 8'h40,
    parameter int          HB_PERIOD     = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [24*NREQ-1:0] colour,
    input  logic [16*NREQ-1:0] hold_ms,
    output logic [NREQ-1:0]   grant,
    output logic              done,
    output logic              busy,
    output logic              curren,
    output logic              rgbleden,
    output logic              red_pwm,
    output logic              green_pwm,
    output logic              blue_pwm
);

    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int HB_W   = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t              state, state_nxt;
    logic [PRE_W-1:0]    pre_cnt;
    logic                tick;
    logic [HB_W-1:0]     hb_cnt;
    logic [WARM_W-1:0]   warm_cnt;
    logic [15:0]         hold_cnt;
    logic [IW-1:0]       win_idx;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       sel;
    logic                any_req;
    rgb_t                shown;
    rgb_t                duty;

    assign tick    = (pre_cnt == '0);
    assign any_req = |req;

    // First requesting index at or after the rotation pointer.
    always_comb begin : arb
        int  idx;
        logic found;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        curren    = 1'b0;
        rgbleden  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        grant     = '0;
        duty      = '0;
        case (state)
            ST_OFF: state_nxt = ST_WARMUP;
            ST_WARMUP: begin
                curren = 1'b1;
                if (warm_cnt == '0) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                curren   = 1'b1;
                rgbleden = 1'b1;
                duty.g   = (hb_cnt < HB_W'(HB_PERIOD / 2)) ? HB_DUTY : 8'h00;
                if (any_req) state_nxt = ST_SHOW;
            end
            ST_SHOW: begin
                curren   = 1'b1;
                rgbleden = 1'b1;
                busy     = 1'b1;
                grant    = NREQ'(1) << win_idx;
                duty     = shown;
                if (hold_cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_OFF;
            pre_cnt  <= PRE_W'(DIV - 1);
            hb_cnt   <= '0;
            warm_cnt <= '0;
            hold_cnt <= '0;
            win_idx  <= '0;
            ptr      <= '0;
            shown    <= '0;
        end else begin
            state   <= state_nxt;
            pre_cnt <= tick ? PRE_W'(DIV - 1) : pre_cnt - 1'b1;
            if (tick)
                hb_cnt <= (hb_cnt == HB_W'(HB_PERIOD - 1)) ? '0 : hb_cnt + 1'b1;
            case (state)
                ST_OFF: warm_cnt <= WARM_W'(WARMUP_CYCLES - 1);
                ST_WARMUP: if (warm_cnt != '0) warm_cnt <= warm_cnt - 1'b1;
                ST_IDLE: if (any_req) begin
                    win_idx  <= sel;
                    ptr      <= (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
                    shown    <= unpack_colour(colour[24*int'(sel) +: 24]);
                    hold_cnt <= hold_ms[16*int'(sel) +: 16];
                end
                ST_SHOW: if (tick && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    rgb_pwm u_pwm (
        .clk       (clk),
        .rst_n     (rst_n),
        .duty      (duty),
        .red_pwm   (red_pwm),
        .green_pwm (green_pwm),
        .blue_pwm  (blue_pwm)
    );

endmodule
